// File: rtl/filter_pkg.sv
// Shared definitions for the spatial-filter front end: FSM encoding,
// default frame geometry and the counter-width helper.
package filter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRIME  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_PRIME  = ST_PRIME,
        S_STREAM = ST_STREAM,
        S_DONE   = ST_DONE
    } state_e;

    localparam int DEF_ROW_WIDTH  = 340;
    localparam int DEF_COL_HEIGHT = 240;
    localparam int DEF_MASK_WIDTH = 7;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Column/row position of the next pixel in raster order, with clear,
// enable and wrap at the end of a row and at the end of the frame.
module pixel_pos_counter
    import filter_pkg::*;
#(
    parameter int ROW_WIDTH  = DEF_ROW_WIDTH,
    parameter int COL_HEIGHT = DEF_COL_HEIGHT,
    parameter int CW         = cnt_width(DEF_ROW_WIDTH),
    parameter int RW         = cnt_width(DEF_COL_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last_col,
    output logic          last_pix
);

    localparam logic [CW-1:0] LAST_C = CW'(ROW_WIDTH - 1);
    localparam logic [RW-1:0] LAST_R = RW'(COL_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          last_row;

    always_comb begin
        last_col = (col_q == LAST_C);
        last_row = (row_q == LAST_R);
        last_pix = last_col && last_row;
        col_d    = col_q;
        row_d    = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/row_buffer_ctrl.sv
// Frame sequencer for the row-buffer chain: accepts pixels, drives the
// shift enable, and flags complete border-free windows with their centre.
module row_buffer_ctrl
    import filter_pkg::*;
#(
    parameter int ROW_WIDTH  = DEF_ROW_WIDTH,
    parameter int COL_HEIGHT = DEF_COL_HEIGHT,
    parameter int MASK_WIDTH = DEF_MASK_WIDTH,
    localparam int CW        = cnt_width(ROW_WIDTH),
    localparam int RW        = cnt_width(COL_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          pix_in_valid,
    output logic          pix_in_ready,
    output logic          shift_en,
    output logic [CW-1:0] col_cnt,
    output logic [RW-1:0] row_cnt,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          frame_busy,
    output logic          frame_done,
    output logic          err_start,
    output logic [1:0]    state_dbg
);

    localparam logic [CW-1:0] EDGE_C = CW'(MASK_WIDTH - 1);
    localparam logic [RW-1:0] EDGE_R = RW'(MASK_WIDTH - 1);
    localparam logic [CW-1:0] HALF_C = CW'((MASK_WIDTH - 1) / 2);
    localparam logic [RW-1:0] HALF_R = RW'((MASK_WIDTH - 1) / 2);

    state_e        state_q, state_d;
    logic          err_start_q, err_start_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic          accept, cnt_clr, last_col, last_pix, win_hit;

    // Handshake: a pixel transfers on any cycle where pix_in_valid and
    // pix_in_ready are both high; ready does not depend on valid, and
    // nothing shifts or counts on cycles without a transfer.
    assign pix_in_ready = (state_q == S_PRIME) || (state_q == S_STREAM);
    assign accept       = pix_in_valid && pix_in_ready;
    assign shift_en     = accept;

    pixel_pos_counter #(
        .ROW_WIDTH (ROW_WIDTH),
        .COL_HEIGHT(COL_HEIGHT),
        .CW        (CW),
        .RW        (RW)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (accept),
        .col     (col_cnt),
        .row     (row_cnt),
        .last_col(last_col),
        .last_pix(last_pix)
    );

    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        err_start_d = err_start_q;
        if (frame_start && (state_q != S_IDLE)) begin
            err_start_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_PRIME;
                    cnt_clr = 1'b1;
                end
            end
            S_PRIME: begin
                if (accept && (col_cnt == EDGE_C) && (row_cnt == EDGE_R)) begin
                    state_d = last_pix ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (accept && last_col && last_pix) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Once in STREAM every row is deep enough; only the column border applies.
    always_comb begin
        win_hit     = accept && (col_cnt >= EDGE_C) &&
                      ((state_q == S_STREAM) || (row_cnt >= EDGE_R));
        win_valid_d = win_hit;
        win_row_d   = win_hit ? row_cnt - HALF_R : win_row_q;
        win_col_d   = win_hit ? col_cnt - HALF_C : win_col_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            err_start_q <= 1'b0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            err_start_q <= err_start_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign err_start  = err_start_q;
    assign frame_busy = (state_q == S_PRIME) || (state_q == S_STREAM);
    assign frame_done = (state_q == S_DONE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_row_buffer_ctrl.sv
// Bench for row_buffer_ctrl on a small 10x8 frame with a 3x3 window,
// using a raster-index reference model and a window scoreboard.
module tb_row_buffer_ctrl;

    localparam int W     = 10;
    localparam int H     = 8;
    localparam int M     = 3;
    localparam int CW    = $clog2(W);
    localparam int RW    = $clog2(H);
    localparam int TOTAL = W * H;
    localparam int NWIN  = (W - M + 1) * (H - M + 1);
    localparam int HALF  = (M - 1) / 2;

    logic          clk = 1'b0;
    logic          reset, frame_start, pix_in_valid;
    logic          pix_in_ready, shift_en, win_valid, frame_busy, frame_done, err_start;
    logic [CW-1:0] col_cnt, win_col;
    logic [RW-1:0] row_cnt, win_row;
    logic [1:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int g_shift, g_win, g_win_err, g_pos_err, g_ctl_err, g_done_cnt, g_done_err, g_timeout;
    logic          seen_v [TOTAL];
    int            seen_r [TOTAL];
    int            seen_c [TOTAL];
    logic [CW+RW-1:0] exp_q[$];

    row_buffer_ctrl #(.ROW_WIDTH(W), .COL_HEIGHT(H), .MASK_WIDTH(M)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_in_valid(pix_in_valid),
        .pix_in_ready(pix_in_ready),
        .shift_en    (shift_en),
        .col_cnt     (col_cnt),
        .row_cnt     (row_cnt),
        .win_valid   (win_valid),
        .win_row     (win_row),
        .win_col     (win_col),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .err_start   (err_start),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    // Drives one frame from IDLE. inj_idx pulses frame_start in the cycle
    // where inj_idx pixels have been accepted (TOTAL = the DONE cycle);
    // stop_at >= 0 abandons the frame after that many accepts.
    task automatic drive_frame(input int pct, input int inj_idx, input int stop_at);
        int idx, tail, prev_idx;
        bit acc, prev_acc, inj_done;
        logic [CW+RW-1:0] got;
        g_shift = 0; g_win = 0; g_win_err = 0; g_pos_err = 0; g_ctl_err = 0;
        g_done_cnt = 0; g_done_err = 0; g_timeout = 1;
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) seen_v[i] = 1'b0;
        @(posedge clk); #1;
        frame_start  = 1'b1;
        pix_in_valid = ($urandom_range(0, 99) < pct);
        @(negedge clk);
        if (pix_in_ready !== 1'b0 || shift_en !== 1'b0 || frame_busy !== 1'b0 ||
            col_cnt !== '0 || row_cnt !== '0) g_ctl_err++;
        idx = 0; tail = 0; prev_acc = 0; prev_idx = 0; inj_done = 0;
        for (int cyc = 0; cyc < 4 * TOTAL + 100; cyc++) begin
            @(posedge clk); #1;
            frame_start = (!inj_done && idx == inj_idx);
            if (frame_start) inj_done = 1;
            pix_in_valid = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            if (win_valid) begin
                g_win++;
                if (exp_q.size() == 0) g_win_err++;
                else begin
                    got = exp_q.pop_front();
                    if ({win_row, win_col} !== got) g_win_err++;
                end
            end else if (exp_q.size() != 0) begin
                g_win_err++;
                void'(exp_q.pop_front());
            end
            if (prev_acc) begin
                seen_v[prev_idx] = win_valid;
                seen_r[prev_idx] = int'(win_row);
                seen_c[prev_idx] = int'(win_col);
            end
            if (idx == TOTAL) tail++;
            if (pix_in_ready !== (idx < TOTAL) || frame_busy !== (idx < TOTAL)) g_ctl_err++;
            if (frame_done === 1'b1) g_done_cnt++;
            if (frame_done !== (tail == 1)) g_done_err++;
            if (idx < TOTAL && (col_cnt !== CW'(idx % W) || row_cnt !== RW'(idx / W))) g_pos_err++;
            acc = pix_in_valid && (idx < TOTAL);
            if (shift_en !== acc) g_ctl_err++;
            prev_acc = acc;
            prev_idx = idx;
            if (acc) begin
                g_shift++;
                if (idx / W >= M - 1 && idx % W >= M - 1)
                    exp_q.push_back({RW'(idx / W - HALF), CW'(idx % W - HALF)});
                idx++;
            end
            if (tail == 2 || (stop_at >= 0 && idx == stop_at)) begin
                g_timeout = 0;
                break;
            end
        end
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; frame_start = 1'b0; pix_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; pix_in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
        n_tests++; if (pix_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", pix_in_ready); end
        n_tests++; if (col_cnt !== '0 || row_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", row_cnt, col_cnt); end
        n_tests++; if (win_valid !== 1'b0 || win_row !== '0 || win_col !== '0) begin n_fail++; $display("FAIL rst_win: got %b %0d %0d want 0 0 0", win_valid, win_row, win_col); end
        n_tests++; if (frame_done !== 1'b0 || frame_busy !== 1'b0) begin n_fail++; $display("FAIL rst_frame: got done=%b busy=%b want 0 0", frame_done, frame_busy); end
        n_tests++; if (err_start !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_start); end
    endtask

    task automatic test_idle_valid();
        pix_in_valid = 1'b1; frame_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (shift_en !== 1'b0 || col_cnt !== '0 || row_cnt !== '0 || pix_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_valid: cycle %0d shift=%b ready=%b col=%0d row=%0d want all 0", i, shift_en, pix_in_ready, col_cnt, row_cnt);
            end
        end
        pix_in_valid = 1'b0;
    endtask

    task automatic test_full_frame();
        drive_frame(100, -1, -1);
        n_tests++; if (g_timeout != 0) begin n_fail++; $display("FAIL full_timeout: frame did not finish"); end
        n_tests++; if (g_shift != TOTAL) begin n_fail++; $display("FAIL full_shift: got %0d want %0d", g_shift, TOTAL); end
        n_tests++; if (g_win != NWIN) begin n_fail++; $display("FAIL full_win: got %0d want %0d", g_win, NWIN); end
        n_tests++; if (g_win_err != 0 || g_pos_err != 0 || g_ctl_err != 0) begin n_fail++; $display("FAIL full_model: win_err=%0d pos_err=%0d ctl_err=%0d want 0", g_win_err, g_pos_err, g_ctl_err); end
        n_tests++; if (g_done_cnt != 1 || g_done_err != 0) begin n_fail++; $display("FAIL full_done: pulses=%0d timing_err=%0d want 1 0", g_done_cnt, g_done_err); end
        n_tests++; if (seen_v[(M-1)*W + M-2] !== 1'b0) begin n_fail++; $display("FAIL full_prewin: got %b want 0", seen_v[(M-1)*W + M-2]); end
        n_tests++; if (seen_v[(M-1)*W + M-1] !== 1'b1 || seen_r[(M-1)*W + M-1] != HALF || seen_c[(M-1)*W + M-1] != HALF) begin
            n_fail++; $display("FAIL full_firstwin: got %b (%0d,%0d) want 1 (%0d,%0d)", seen_v[(M-1)*W + M-1], seen_r[(M-1)*W + M-1], seen_c[(M-1)*W + M-1], HALF, HALF);
        end
    endtask

    task automatic test_random_frame();
        drive_frame(50, -1, -1);
        n_tests++; if (g_timeout != 0) begin n_fail++; $display("FAIL rand_timeout: frame did not finish"); end
        n_tests++; if (g_shift != TOTAL) begin n_fail++; $display("FAIL rand_shift: got %0d want %0d", g_shift, TOTAL); end
        n_tests++; if (g_win != NWIN) begin n_fail++; $display("FAIL rand_win: got %0d want %0d", g_win, NWIN); end
        n_tests++; if (g_win_err != 0 || g_pos_err != 0 || g_ctl_err != 0) begin n_fail++; $display("FAIL rand_model: win_err=%0d pos_err=%0d ctl_err=%0d want 0", g_win_err, g_pos_err, g_ctl_err); end
        n_tests++; if (g_done_cnt != 1 || g_done_err != 0) begin n_fail++; $display("FAIL rand_done: pulses=%0d timing_err=%0d want 1 0", g_done_cnt, g_done_err); end
    endtask

    task automatic test_border();
        drive_frame(60, -1, -1);
        n_tests++; if (seen_v[5*W + 0] !== 1'b0 || seen_v[5*W + 1] !== 1'b0) begin n_fail++; $display("FAIL border_col01: got %b %b want 0 0", seen_v[5*W], seen_v[5*W + 1]); end
        n_tests++; if (seen_v[5*W + 2] !== 1'b1 || seen_r[5*W + 2] != 4 || seen_c[5*W + 2] != 1) begin
            n_fail++; $display("FAIL border_5_2: got %b (%0d,%0d) want 1 (4,1)", seen_v[5*W + 2], seen_r[5*W + 2], seen_c[5*W + 2]);
        end
        n_tests++; if (seen_v[(M-2)*W + W-1] !== 1'b0) begin n_fail++; $display("FAIL border_prime_row: got %b want 0", seen_v[(M-2)*W + W-1]); end
    endtask

    task automatic test_start_midframe();
        drive_frame(50, 50, -1);
        n_tests++; if (g_shift != TOTAL || g_win != NWIN) begin n_fail++; $display("FAIL mid_start_counts: got %0d/%0d want %0d/%0d", g_shift, g_win, TOTAL, NWIN); end
        n_tests++; if (g_win_err != 0 || g_ctl_err != 0 || g_done_cnt != 1 || g_timeout != 0) begin n_fail++; $display("FAIL mid_start_model: win_err=%0d ctl_err=%0d done=%0d to=%0d want 0 0 1 0", g_win_err, g_ctl_err, g_done_cnt, g_timeout); end
        n_tests++; if (err_start !== 1'b1) begin n_fail++; $display("FAIL mid_start_err: got %b want 1", err_start); end
    endtask

    task automatic test_start_in_done();
        drive_frame(100, TOTAL, -1);
        n_tests++; if (g_ctl_err != 0 || g_done_err != 0) begin n_fail++; $display("FAIL done_start_model: ctl_err=%0d done_err=%0d want 0 0", g_ctl_err, g_done_err); end
        repeat (3) @(negedge clk);
        n_tests++; if (state_dbg !== 2'd0 || pix_in_ready !== 1'b0) begin n_fail++; $display("FAIL done_start_idle: got state=%0d ready=%b want 0 0", state_dbg, pix_in_ready); end
        n_tests++; if (err_start !== 1'b1) begin n_fail++; $display("FAIL done_start_err: got %b want 1", err_start); end
    endtask

    task automatic test_mid_reset();
        drive_frame(70, -1, 40);
        reset = 1'b0; pix_in_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (state_dbg !== 2'd0 || pix_in_ready !== 1'b0 || shift_en !== 1'b0) begin n_fail++; $display("FAIL mreset_state: got state=%0d ready=%b shift=%b want 0 0 0", state_dbg, pix_in_ready, shift_en); end
        n_tests++; if (col_cnt !== '0 || row_cnt !== '0 || win_valid !== 1'b0 || win_row !== '0 || win_col !== '0) begin
            n_fail++; $display("FAIL mreset_outs: got col=%0d row=%0d wv=%b wr=%0d wc=%0d want 0", col_cnt, row_cnt, win_valid, win_row, win_col);
        end
        n_tests++; if (err_start !== 1'b0 || frame_done !== 1'b0 || frame_busy !== 1'b0) begin n_fail++; $display("FAIL mreset_flags: got err=%b done=%b busy=%b want 0 0 0", err_start, frame_done, frame_busy); end
        drive_frame(50, -1, -1);
        n_tests++; if (g_shift != TOTAL || g_win != NWIN || g_timeout != 0) begin n_fail++; $display("FAIL mreset_frame: got %0d/%0d to=%0d want %0d/%0d 0", g_shift, g_win, g_timeout, TOTAL, NWIN); end
        n_tests++; if (g_win_err != 0 || g_pos_err != 0 || g_ctl_err != 0 || g_done_err != 0) begin n_fail++; $display("FAIL mreset_model: errs %0d %0d %0d %0d want 0", g_win_err, g_pos_err, g_ctl_err, g_done_err); end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            drive_frame((f == 0) ? 100 : 30, -1, -1);
            n_tests++; if (g_shift != TOTAL || g_win != NWIN || g_done_cnt != 1 || g_timeout != 0) begin
                n_fail++; $display("FAIL b2b_frame%0d: got shift=%0d win=%0d done=%0d to=%0d want %0d %0d 1 0", f, g_shift, g_win, g_done_cnt, g_timeout, TOTAL, NWIN);
            end
            n_tests++; if (g_win_err != 0 || g_pos_err != 0 || g_ctl_err != 0 || g_done_err != 0) begin
                n_fail++; $display("FAIL b2b_model%0d: errs %0d %0d %0d %0d want 0", f, g_win_err, g_pos_err, g_ctl_err, g_done_err);
            end
        end
    endtask

    initial begin
        reset = 1'b0; frame_start = 1'b0; pix_in_valid = 1'b0;
        test_reset();
        test_idle_valid();
        test_full_frame();
        test_random_frame();
        test_border();
        test_start_midframe();
        test_start_in_done();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/row_buffer_ctrl.md
Name: row_buffer_ctrl

Overview:
- Sequences the 7x7 row-buffer chain of the window-based spatial filter for one frame at a time.
- Accepts the incoming pixel stream under a valid/ready handshake and produces the shift enable for the row buffers.
- Tracks pixel column/row position and flags when the buffer outputs hold a complete, border-free window, giving its centre coordinates.
- Signals frame completion and reports protocol errors.

Parameters:
- ROW_WIDTH, 340, pixels per image row.
- COL_HEIGHT, 240, rows per frame.
- MASK_WIDTH, 7, window side length; odd, at least 3, at most COL_HEIGHT and ROW_WIDTH.
- CW, $clog2(ROW_WIDTH), derived localparam, column counter width.
- RW, $clog2(COL_HEIGHT), derived localparam, row counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; reset=0 sampled on a clk edge resets the block.
- frame_start  in  1  single-cycle request to begin a frame.
- pix_in_valid  in  1  upstream pixel valid.
- pix_in_ready  out  1  block can accept a pixel this cycle.
- shift_en  out  1  row-buffer shift enable; equals accept (combinational).
- col_cnt  out  CW  column of the next pixel to be accepted.
- row_cnt  out  RW  row of the next pixel to be accepted.
- win_valid  out  1  registered; a full window is present at the row-buffer outputs.
- win_row  out  RW  registered; centre row of the flagged window.
- win_col  out  CW  registered; centre column of the flagged window.
- frame_busy  out  1  high in PRIME and STREAM.
- frame_done  out  1  single-cycle pulse at end of frame.
- err_start  out  1  sticky; frame_start seen while not IDLE.

Behaviour:
- accept = pix_in_valid & pix_in_ready. shift_en = accept. The row buffers and the window register shift only on shift_en, so upstream gaps are legal.
- Reset (reset=0 at an edge): state goes to IDLE. col_cnt, row_cnt, win_valid, win_row, win_col, frame_done and err_start all go to 0. Pending in-flight state is discarded, including mid-frame.
- FSM states: IDLE, PRIME, STREAM, DONE.
- IDLE:
  - pix_in_ready=0.
  - frame_start=1 -> PRIME, with col_cnt=0 and row_cnt=0.
- PRIME:
  - pix_in_ready=1.
  - Accepting the pixel at (row=MASK_WIDTH-1, col=MASK_WIDTH-1) -> STREAM.
- STREAM:
  - pix_in_ready=1.
  - Accepting the pixel at (COL_HEIGHT-1, ROW_WIDTH-1) -> DONE.
- DONE:
  - pix_in_ready=0 and frame_done=1 for exactly one cycle.
  - Next state IDLE; counters return to 0.
- Counters:
  - On accept, col_cnt increments.
  - When col_cnt=ROW_WIDTH-1, col_cnt wraps to 0 and row_cnt increments.
  - At the last pixel both counters wrap to 0.
  - No change without accept.
- Window flag:
  - The cycle after accepting pixel (r,c) with r>=MASK_WIDTH-1 and c>=MASK_WIDTH-1: win_valid=1, win_row=r-(MASK_WIDTH-1)/2, win_col=c-(MASK_WIDTH-1)/2.
  - Otherwise win_valid=0 the cycle after. Latency is 1 cycle; win_valid is never high for two cycles from one accept.
- No-border rule:
  - Columns 0..MASK_WIDTH-2 of every row produce no window, including after row wrap. Only the PRIME state enforces the rows condition.
  - Windows per frame = (ROW_WIDTH-MASK_WIDTH+1)*(COL_HEIGHT-MASK_WIDTH+1); defaults give 334*234 = 78156.
- Errors and simultaneous events:
  - frame_start in PRIME, STREAM or DONE is ignored and sets err_start. It clears only on reset.
  - frame_start in the same cycle as the DONE->IDLE transition is ignored; a new frame needs frame_start while in IDLE.
  - pix_in_valid in IDLE or DONE is not accepted: no shift and no count.

Decomposition:
- Shared package filter_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_PRIME=2'd1, ST_STREAM=2'd2, ST_DONE=2'd3;
  - the default geometry constants;
  - the clog2-based width function.
- One sub-module, pixel_pos_counter: a column/row counter with enable, clear and wrap, exposing last_col and last_pix flags.

Test Plan:
- Defaults, frame_start, then pix_in_valid held high -> first win_valid the cycle after the 2047th accept (pixel 6,6), with win_row=3 and win_col=3. Exactly 78156 win_valid pulses. frame_done is one cycle, 1 cycle after accepting pixel (239,339).
- ROW_WIDTH=10, COL_HEIGHT=8, MASK_WIDTH=3, pix_in_valid random 50% -> shift_en count = 80, win_valid count = 48. No win_valid after accepts at col 0 or 1. Counters frozen on idle cycles.
- Same small config, pixel (5,0) accepted -> no win_valid. Pixel (5,2) accepted -> win_valid with win_row=4, win_col=1.
- frame_start pulsed mid-STREAM -> err_start=1 and stays 1. Frame continues and ends normally with 48 windows (small config).
- reset=0 for one edge mid-STREAM -> next cycle state IDLE, pix_in_ready=0, all outputs 0. A following frame_start yields a complete, correct frame.
- pix_in_valid=1 in IDLE with no frame_start for 20 cycles -> shift_en=0 and col_cnt=0 throughout.
